// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared FSM encoding and hex-to-segment table for seq_mult_seg7
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a}; entry 0 sits in the least significant byte.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex nibble to active-low 7-segment code
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [7:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seq_mult_seg7.sv
// rtl/seq_mult_seg7.sv - shift-add multiplier with multiplexed hex 7-segment display
// Optional leading-zero blanking: SEG7_ZERO_BLANK_EN.
module seq_mult_seg7
    import seg7_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 10
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done,
    output logic [DIGITS-1:0]    digits,
    output logic [7:0]           number
);

    localparam int PW = 2 * WIDTH;
    localparam int DB = $clog2(DIGITS);
    localparam int SW = SCAN_DIV + DB;
    localparam int CW = $clog2(WIDTH);
    localparam int XW = 4 * DIGITS;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    acc_nxt;
    logic [CW-1:0]    cnt;
    logic             last_step;

    logic [SW-1:0]    scan_cnt;
    logic [DB-1:0]    dig_idx;
    logic [XW-1:0]    prod_ext;
    logic [3:0]       nibble;
    logic [7:0]       seg_code;
    logic             blank;
    logic [7:0]       number_nxt;

    assign last_step = (cnt == CW'(WIDTH - 1));
    assign acc_nxt   = b_reg[0] ? (acc + (PW'(a_reg) << cnt)) : acc;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BUSY;
            BUSY:    if (last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            BUSY: busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // product only moves on the final step, so it is never seen half-built.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    acc   <= acc_nxt;
                    b_reg <= b_reg >> 1;
                    cnt   <= cnt + CW'(1);
                    if (last_step) product <= acc_nxt;
                end
                default: ;
            endcase
        end
    end

    assign dig_idx  = scan_cnt[SCAN_DIV +: DB];
    assign prod_ext = XW'(product);
    assign nibble   = prod_ext[{dig_idx, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .hex (nibble),
        .seg (seg_code)
    );

`ifdef SEG7_ZERO_BLANK_EN
    logic [DB-1:0] top_nz;

    // Digit 0 is never blanked, so the search starts at nibble 1.
    always_comb begin
        top_nz = '0;
        for (int k = 1; k < DIGITS; k++) begin
            if (prod_ext[4*k +: 4] != 4'h0) top_nz = DB'(k);
        end
    end

    assign blank = (dig_idx > top_nz);
`else
    assign blank = 1'b0;
`endif

    assign number_nxt = blank ? SEG_BLANK : (seg_code | 8'h80);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            scan_cnt <= '0;
            digits   <= '1;
            number   <= SEG_BLANK;
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
            digits   <= ~(DIGITS'(1) << dig_idx);
            number   <= number_nxt;
        end
    end

endmodule

// File: tb/tb_seq_mult_seg7.sv
// tb/tb_seq_mult_seg7.sv - self-checking bench for seq_mult_seg7 (4x4/8-digit and 8x8/4-digit)
module tb_seq_mult_seg7;

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    logic       s0;
    logic [3:0] a0, b0;
    logic [7:0] p0;
    logic       busy0, done0;
    logic [7:0] dg0, n0;

    logic        s1;
    logic [7:0]  a1, b1;
    logic [15:0] p1;
    logic        busy1, done1;
    logic [3:0]  dg1;
    logic [7:0]  n1;

    int total = 0;
    int bad   = 0;

    logic [7:0] segref [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seq_mult_seg7 #(.WIDTH(4), .DIGITS(8), .SCAN_DIV(2)) u0 (
        .CLK(CLK), .RST_N(RST_N), .start(s0), .a(a0), .b(b0),
        .product(p0), .busy(busy0), .done(done0), .digits(dg0), .number(n0)
    );

    seq_mult_seg7 #(.WIDTH(8), .DIGITS(4), .SCAN_DIV(2)) u1 (
        .CLK(CLK), .RST_N(RST_N), .start(s1), .a(a1), .b(b1),
        .product(p1), .busy(busy1), .done(done1), .digits(dg1), .number(n1)
    );

    function automatic logic [7:0] exp_num(input int p, input int i);
        int rest;
        rest = p >> (4 * i);
`ifdef SEG7_ZERO_BLANK_EN
        if (i > 0 && rest == 0) return 8'hFF;
`endif
        return segref[rest & 15];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mult0(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] e;
        e = x * y;
        a0 = x; b0 = y; s0 = 1'b1;
        @(posedge CLK); #1;
        chk("m0_busy_e0", busy0, 1);
        chk("m0_done_e0", done0, 0);
        s0 = 1'b0; a0 = 4'($urandom); b0 = 4'($urandom);
        repeat (3) begin
            @(posedge CLK); #1;
            chk("m0_no_early_done", done0, 0);
        end
        @(posedge CLK); #1;
        chk("m0_done", done0, 1);
        chk("m0_busy_done", busy0, 1);
        chk("m0_product", p0, e);
        @(posedge CLK); #1;
        chk("m0_done_drop", done0, 0);
        chk("m0_busy_drop", busy0, 0);
        chk("m0_product_hold", p0, e);
    endtask

    task automatic mult1(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] e;
        e = x * y;
        a1 = x; b1 = y; s1 = 1'b1;
        @(posedge CLK); #1;
        chk("m1_busy_e0", busy1, 1);
        s1 = 1'b0; a1 = 8'($urandom); b1 = 8'($urandom);
        repeat (7) begin
            @(posedge CLK); #1;
            chk("m1_no_early_done", done1, 0);
        end
        @(posedge CLK); #1;
        chk("m1_done", done1, 1);
        chk("m1_product", p1, e);
        @(posedge CLK); #1;
        chk("m1_done_drop", done1, 0);
        chk("m1_busy_drop", busy1, 0);
    endtask

    task automatic disp0(input int p);
        logic [7:0] want;
        int w;
        for (int i = 0; i < 8; i++) begin
            want = ~(8'd1 << i);
            w = 0;
            while (dg0 !== want && w < 64) begin
                @(posedge CLK); #1;
                w++;
            end
            chk("disp0_select", dg0, want);
            chk($sformatf("disp0_digit%0d", i), n0, exp_num(p, i));
        end
    endtask

    task automatic disp1(input int p);
        logic [3:0] want;
        int w;
        for (int i = 0; i < 4; i++) begin
            want = ~(4'd1 << i);
            w = 0;
            while (dg1 !== want && w < 64) begin
                @(posedge CLK); #1;
                w++;
            end
            chk("disp1_select", dg1, want);
            chk($sformatf("disp1_digit%0d", i), n1, exp_num(p, i));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_p;
        logic [7:0] want0;
        logic [3:0] want1;

        RST_N = 1'b0;
        s0 = 1'b0; a0 = '0; b0 = '0;
        s1 = 1'b0; a1 = '0; b1 = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_product", p0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_digits", dg0, 8'hFF);
        chk("rst_number", n0, 8'hFF);
        chk("rst_digits1", dg1, 4'hF);
        chk("rst_number1", n1, 8'hFF);
        RST_N = 1'b1;

        // Scan sequence from a known counter origin: each digit held 4 cycles.
        for (int n = 1; n <= 36; n++) begin
            @(posedge CLK); #1;
            want0 = ~(8'd1 << (((n - 1) >> 2) % 8));
            want1 = ~(4'd1 << (((n - 1) >> 2) % 4));
            chk("scan_digits0", dg0, want0);
            chk("scan_digits1", dg1, want1);
            chk("scan_number0", n0, exp_num(0, ((n - 1) >> 2) % 8));
        end

        mult0(4'd15, 4'd15);
        disp0(8'hE1);
        mult0(4'd0, 4'd9);
        disp0(0);
        mult0(4'd7, 4'd0);

        repeat (6) mult0(4'($urandom), 4'($urandom));

        mult1(8'd255, 8'd255);
        disp1(16'hFE01);
        mult1(8'd1, 8'd1);
        disp1(16'h0001);
        repeat (3) mult1(8'($urandom), 8'($urandom));

        // start held high: operands captured only every WIDTH+2 edges.
        s0 = 1'b1; a0 = 4'($urandom); b0 = 4'($urandom);
        exp_p = 0;
        for (int k = 0; k < 24; k++) begin
            if (k % 6 == 0) exp_p = a0 * b0;
            @(posedge CLK); #1;
            chk("cont_done", done0, (k % 6 == 4) ? 1 : 0);
            if (k % 6 == 4) chk("cont_product", p0, exp_p);
            a0 = 4'($urandom); b0 = 4'($urandom);
        end
        s0 = 1'b0;
        @(posedge CLK); #1;

        mult0(4'd6, 4'd7);

        a0 = 4'd9; b0 = 4'd13; s0 = 1'b1;
        @(posedge CLK); #1;
        s0 = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b0;
        #1;
        chk("abort_product", p0, 0);
        chk("abort_busy", busy0, 0);
        chk("abort_done", done0, 0);
        chk("abort_digits", dg0, 8'hFF);
        chk("abort_number", n0, 8'hFF);
        chk("abort_product1", p1, 0);
        repeat (2) begin
            @(posedge CLK); #1;
            chk("abort_no_done", done0, 0);
        end
        RST_N = 1'b1;
        @(posedge CLK); #1;
        chk("abort_idle_after", busy0, 0);
        mult0(4'd3, 4'd5);
        disp0(8'h0F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
